frost32_mem_access_arbiter: RTL and testbench

//  Parametrised N-channel arbiter between Frost32 requesters (fetch, load/store, future DMA) and a single

---
 rtl/frost32_mem_access_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_frost32_mem_access_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frost32_mem_access_arbiter.sv
// Round-robin arbiter between N Frost32 requesters and one memory port using the
// req_mem_access / wait_for_mem handshake, with alignment checks, lane steering and timeout.
module frost32_mem_access_arbiter #(
    parameter int unsigned NUM_CHANNELS   = 2,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,

    input  logic [NUM_CHANNELS-1:0]            ch_req_i,
    input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] ch_addr_i,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_wdata_i,
    input  logic [NUM_CHANNELS-1:0]            ch_access_type_i,
    input  logic [NUM_CHANNELS*2-1:0]          ch_access_size_i,
    output logic [NUM_CHANNELS-1:0]            ch_done_o,
    output logic [NUM_CHANNELS-1:0]            ch_error_o,
    output logic [DATA_WIDTH-1:0]              ch_rdata_o,

    output logic                               mem_req_o,
    output logic [ADDR_WIDTH-1:0]              mem_addr_o,
    output logic [DATA_WIDTH-1:0]              mem_wdata_o,
    output logic                               mem_access_type_o,
    output logic [1:0]                         mem_access_size_o,
    input  logic [DATA_WIDTH-1:0]              mem_rdata_i,
    input  logic                               mem_wait_i
);

    localparam int unsigned PTR_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned LANES8  = DATA_WIDTH / 8;
    localparam int unsigned LANES16 = DATA_WIDTH / 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W-1:0] LAST_CH  = PTR_W'(NUM_CHANNELS - 1);

    localparam logic [1:0] DIAS32 = 2'd0;
    localparam logic [1:0] DIAS16 = 2'd1;
    localparam logic [1:0] DIAS8  = 2'd2;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StWait = 1'b1
    } state_e;

    state_e                  state_q;
    logic [PTR_W-1:0]        rr_ptr_q;
    logic [PTR_W-1:0]        win_q;
    logic [CNT_W-1:0]        wait_cnt_q;
    logic [NUM_CHANNELS-1:0] ch_done_q;
    logic [NUM_CHANNELS-1:0] ch_error_q;
    logic [DATA_WIDTH-1:0]   ch_rdata_q;
    logic                    mem_req_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic                    mem_access_type_q;
    logic [1:0]              mem_access_size_q;

    logic                    any_req;
    logic [PTR_W-1:0]        win_idx;
    int                      scan_idx;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [DATA_WIDTH-1:0]   sel_wdata_rep;
    logic                    sel_type;
    logic [1:0]              sel_size;
    logic                    sel_legal;
    logic [DATA_WIDTH-1:0]   rd_lane;

    function automatic logic [NUM_CHANNELS-1:0] ch_onehot(input logic [PTR_W-1:0] idx);
        logic [NUM_CHANNELS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
        return (idx == LAST_CH) ? '0 : PTR_W'(idx + 1'b1);
    endfunction

    // Scan from the highest offset down so the channel nearest rr_ptr is written last and wins.
    always_comb begin
        any_req  = 1'b0;
        win_idx  = '0;
        scan_idx = 0;
        for (int off = int'(NUM_CHANNELS) - 1; off >= 0; off--) begin
            scan_idx = int'(rr_ptr_q) + off;
            if (scan_idx >= int'(NUM_CHANNELS)) begin
                scan_idx = scan_idx - int'(NUM_CHANNELS);
            end
            if (ch_req_i[scan_idx]) begin
                any_req = 1'b1;
                win_idx = PTR_W'(scan_idx);
            end
        end
    end

    assign sel_addr  = ch_addr_i[32'(win_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = ch_wdata_i[32'(win_idx) * DATA_WIDTH +: DATA_WIDTH];
    assign sel_type  = ch_access_type_i[win_idx];
    assign sel_size  = ch_access_size_i[32'(win_idx) * 2 +: 2];

    always_comb begin
        sel_legal = 1'b0;
        case (sel_size)
            DIAS32:  sel_legal = (sel_addr[1:0] == 2'b00);
            DIAS16:  sel_legal = ~sel_addr[0];
            DIAS8:   sel_legal = 1'b1;
            default: sel_legal = 1'b0;
        endcase
    end

    always_comb begin
        sel_wdata_rep = sel_wdata;
        case (sel_size)
            DIAS16:  sel_wdata_rep = {LANES16{sel_wdata[15:0]}};
            DIAS8:   sel_wdata_rep = {LANES8{sel_wdata[7:0]}};
            default: sel_wdata_rep = sel_wdata;
        endcase
    end

    always_comb begin
        rd_lane = '0;
        case (mem_access_size_q)
            DIAS16:  rd_lane[15:0] = mem_rdata_i[{mem_addr_q[1], 4'b0000} +: 16];
            DIAS8:   rd_lane[7:0]  = mem_rdata_i[{mem_addr_q[1:0], 3'b000} +: 8];
            default: rd_lane       = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= StIdle;
            rr_ptr_q          <= '0;
            win_q             <= '0;
            wait_cnt_q        <= '0;
            ch_done_q         <= '0;
            ch_error_q        <= '0;
            ch_rdata_q        <= '0;
            mem_req_q         <= 1'b0;
            mem_addr_q        <= '0;
            mem_wdata_q       <= '0;
            mem_access_type_q <= 1'b0;
            mem_access_size_q <= '0;
        end else begin
            ch_done_q  <= '0;
            ch_error_q <= '0;
            case (state_q)
                StIdle: begin
                    // The ch_done cycle doubles as bus turnaround: the finishing requester
                    // still holds ch_req here, so no grant is made in it.
                    if (any_req && (ch_done_q == '0)) begin
                        if (sel_legal) begin
                            mem_req_q         <= 1'b1;
                            mem_addr_q        <= sel_addr;
                            mem_wdata_q       <= sel_wdata_rep;
                            mem_access_type_q <= sel_type;
                            mem_access_size_q <= sel_size;
                            win_q             <= win_idx;
                            wait_cnt_q        <= '0;
                            state_q           <= StWait;
                        end else begin
                            ch_done_q  <= ch_onehot(win_idx);
                            ch_error_q <= ch_onehot(win_idx);
                            rr_ptr_q   <= next_ptr(win_idx);
                        end
                    end
                end
                StWait: begin
                    if (!mem_wait_i) begin
                        mem_req_q <= 1'b0;
                        ch_done_q <= ch_onehot(win_q);
                        if (!mem_access_type_q) begin
                            ch_rdata_q <= rd_lane;
                        end
                        rr_ptr_q <= next_ptr(win_q);
                        state_q  <= StIdle;
                    end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt_q == CNT_LAST)) begin
                        mem_req_q  <= 1'b0;
                        ch_done_q  <= ch_onehot(win_q);
                        ch_error_q <= ch_onehot(win_q);
                        rr_ptr_q   <= next_ptr(win_q);
                        state_q    <= StIdle;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ch_done_o         = ch_done_q;
    assign ch_error_o        = ch_error_q;
    assign ch_rdata_o        = ch_rdata_q;
    assign mem_req_o         = mem_req_q;
    assign mem_addr_o        = mem_addr_q;
    assign mem_wdata_o       = mem_wdata_q;
    assign mem_access_type_o = mem_access_type_q;
    assign mem_access_size_o = mem_access_size_q;

endmodule

// File: tb/tb_frost32_mem_access_arbiter.sv
// Bench for frost32_mem_access_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_frost32_mem_access_arbiter;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]    ch_req;
    logic [N*AW-1:0] ch_addr;
    logic [N*DW-1:0] ch_wdata;
    logic [N-1:0]    ch_type;
    logic [2*N-1:0]  ch_size;
    logic [N-1:0]    ch_done;
    logic [N-1:0]    ch_error;
    logic [DW-1:0]   ch_rdata;
    logic            mem_req;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_type;
    logic [1:0]      mem_size;
    logic [DW-1:0]   mem_rdata;
    logic            mem_wait;

    frost32_mem_access_arbiter #(
        .NUM_CHANNELS  (N),
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ch_req_i         (ch_req),
        .ch_addr_i        (ch_addr),
        .ch_wdata_i       (ch_wdata),
        .ch_access_type_i (ch_type),
        .ch_access_size_i (ch_size),
        .ch_done_o        (ch_done),
        .ch_error_o       (ch_error),
        .ch_rdata_o       (ch_rdata),
        .mem_req_o        (mem_req),
        .mem_addr_o       (mem_addr),
        .mem_wdata_o      (mem_wdata),
        .mem_access_type_o(mem_type),
        .mem_access_size_o(mem_size),
        .mem_rdata_i      (mem_rdata),
        .mem_wait_i       (mem_wait)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model state.
    bit          pend   [N];
    logic [31:0] m_addr [N];
    logic [31:0] m_wdata[N];
    bit          m_type [N];
    logic [1:0]  m_size [N];
    int          rr_m;
    logic [31:0] rdata_m;
    int          wait_mode;   // 0 = zero wait, 1 = random, 2 = stuck busy
    bit          fixed_rd;
    logic [31:0] fixed_rd_val;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int c);
        logic [N-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    function automatic bit is_legal(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return (a % 4) == 0;
        if (sz == 2'd1) return (a % 2) == 0;
        return sz == 2'd2;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        if (sz == 2'd2) return (wd & 32'hFF) * 32'h0101_0101;
        return wd;
    endfunction

    function automatic logic [31:0] exp_lane(input logic [1:0] sz, input logic [31:0] a,
                                             input logic [31:0] rd);
        if (sz == 2'd1) return (rd >> (16 * (a[1] ? 1 : 0))) & 32'hFFFF;
        if (sz == 2'd2) return (rd >> (8 * int'(a[1:0]))) & 32'hFF;
        return rd;
    endfunction

    task automatic drive_channels();
        for (int c = 0; c < N; c++) begin
            ch_req[c]            = pend[c];
            ch_addr[c*AW +: AW]  = m_addr[c];
            ch_wdata[c*DW +: DW] = m_wdata[c];
            ch_type[c]           = m_type[c];
            ch_size[2*c +: 2]    = m_size[c];
        end
    endtask

    task automatic set_req(input int c, input logic [31:0] a, input logic [1:0] sz,
                           input bit ty, input logic [31:0] wd);
        pend[c]    = 1'b1;
        m_addr[c]  = a;
        m_size[c]  = sz;
        m_type[c]  = ty;
        m_wdata[c] = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Precondition: at a negedge, DUT idle and past any turnaround, pending requests driven.
    task automatic serve_one();
        int          w;
        int          cyc;
        bit          legal;
        bit          fin;
        bit          tmo;
        bit          mw;
        logic [31:0] rd;
        logic [31:0] a;
        logic [1:0]  sz;
        bit          ty;
        w = -1;
        for (int k = 0; k < N; k++) begin
            if (w < 0 && pend[(rr_m + k) % N]) w = (rr_m + k) % N;
        end
        a     = m_addr[w];
        sz    = m_size[w];
        ty    = m_type[w];
        legal = is_legal(sz, a);
        mem_wait = 1'b1;
        tick();
        if (!legal) begin
            check_eq("illegal_no_req", mem_req, 0);
            check_eq("illegal_done", ch_done, onehot(w));
            check_eq("illegal_err", ch_error, onehot(w));
        end else begin
            check_eq("grant_req", mem_req, 1);
            check_eq("grant_addr", mem_addr, a);
            check_eq("grant_wdata", mem_wdata, exp_wdata(sz, m_wdata[w]));
            check_eq("grant_size", mem_size, sz);
            check_eq("grant_type", mem_type, ty);
            check_eq("grant_no_done", ch_done, 0);
            cyc = 0;
            fin = 0;
            tmo = 0;
            while (!fin) begin
                case (wait_mode)
                    0:       mw = 1'b0;
                    2:       mw = 1'b1;
                    default: mw = ($urandom_range(0, 2) != 0);
                endcase
                rd        = fixed_rd ? fixed_rd_val : $urandom;
                mem_wait  = mw;
                mem_rdata = rd;
                if (wait_mode == 1 && $urandom_range(0, 3) == 0) begin
                    pend[w]             = 1'b0;
                    ch_req[w]           = 1'b0;
                    ch_addr[w*AW +: AW] = $urandom;
                end
                tick();
                cyc++;
                if (!mw) begin
                    fin = 1;
                end else if (cyc == TO) begin
                    fin = 1;
                    tmo = 1;
                end else begin
                    check_eq("wait_req", mem_req, 1);
                    check_eq("wait_addr", mem_addr, a);
                    check_eq("wait_no_done", ch_done, 0);
                end
            end
            if (!tmo && !ty) rdata_m = exp_lane(sz, a, rd);
            check_eq("done_req_low", mem_req, 0);
            check_eq("done_vec", ch_done, onehot(w));
            check_eq("done_err", ch_error, tmo ? onehot(w) : '0);
            check_eq("done_rdata", ch_rdata, rdata_m);
        end
        pend[w] = 1'b0;
        rr_m    = (w + 1) % N;
        drive_channels();
        mem_wait = 1'b1;
        tick();
        check_eq("turn_done", ch_done, 0);
        check_eq("turn_req", mem_req, 0);
        check_eq("rdata_hold", ch_rdata, rdata_m);
    endtask

    task automatic serve_all();
        for (int g = 0; g < 4 * N; g++) begin
            bit any;
            any = 0;
            for (int c = 0; c < N; c++) any |= pend[c];
            if (any) serve_one();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < N; c++) begin
            pend[c] = 0; m_addr[c] = '0; m_wdata[c] = '0; m_type[c] = 0; m_size[c] = '0;
        end
        rr_m = 0; rdata_m = '0; wait_mode = 0; fixed_rd = 0; fixed_rd_val = '0;
        mem_wait = 1'b1; mem_rdata = '0;
        drive_channels();
        tick();
        tick();
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_done", ch_done, 0);
        check_eq("rst_err", ch_error, 0);
        check_eq("rst_rdata", ch_rdata, 0);
        check_eq("rst_addr", mem_addr, 0);
        rst_n = 1'b1;
        tick();

        // Simultaneous requests: ch0 first, then ch1, pointer back to 0.
        set_req(0, 32'h0000_0100, 2'd0, 0, 32'h0);
        set_req(1, 32'h0000_0200, 2'd0, 0, 32'h0);
        drive_channels();
        serve_all();

        // Byte read with lane steering.
        fixed_rd = 1; fixed_rd_val = 32'hAABB_CCDD;
        set_req(0, 32'h0000_1003, 2'd2, 0, 32'h0);
        drive_channels();
        serve_one();
        check_eq("t2_rdata", ch_rdata, 32'h0000_00AA);

        // Halfword write replicated over both lanes.
        set_req(1, 32'h0000_2002, 2'd1, 1, 32'h0000_1234);
        drive_channels();
        serve_one();
        fixed_rd = 0;

        // Misaligned word access.
        set_req(0, 32'h0000_2001, 2'd0, 0, 32'h0);
        drive_channels();
        serve_one();

        // Timeout with memory stuck busy.
        wait_mode = 2;
        set_req(0, 32'h0000_0040, 2'd0, 1, 32'hDEAD_BEEF);
        drive_channels();
        serve_one();
        wait_mode = 0;

        // Reset in the middle of a wait.
        set_req(0, 32'h0000_3000, 2'd0, 0, 32'h0);
        drive_channels();
        mem_wait = 1'b1;
        tick();
        check_eq("t6_req_up", mem_req, 1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_req_drop", mem_req, 0);
        check_eq("t6_no_done", ch_done, 0);
        pend[0] = 0;
        drive_channels();
        tick();
        tick();
        rst_n = 1'b1;
        rr_m = 0; rdata_m = '0;
        set_req(1, 32'h0000_3004, 2'd1, 0, 32'h0);
        drive_channels();
        serve_one();

        // Randomized traffic.
        wait_mode = 1;
        for (int it = 0; it < 300; it++) begin
            for (int c = 0; c < N; c++) begin
                if (!pend[c] && $urandom_range(0, 1) == 1) begin
                    set_req(c, $urandom_range(0, 1023), 2'($urandom_range(0, 3)),
                            1'($urandom_range(0, 1)), $urandom);
                end
            end
            begin
                bit any;
                any = 0;
                for (int c = 0; c < N; c++) any |= pend[c];
                if (!any) begin
                    set_req(it % N, $urandom_range(0, 1023), 2'($urandom_range(0, 3)),
                            1'($urandom_range(0, 1)), $urandom);
                end
            end
            drive_channels();
            serve_one();
        end
        serve_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
